// File: rtl/divisor_subtrai_desloca_if.sv
`default_nettype none
// ============================================================================
// Module      : divisor_subtrai_desloca_if
// Description : Operand/result/handshake bundle for the shift-subtract divider.
//               master drives dividendo, divisor and st, and observes the
//               results; slave is the divider side.
//               dividendo [2N] / divisor [N] / st          : master -> slave
//               quociente [N] / resto [N] / ovf/done/idle  : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface divisor_subtrai_desloca_if #(
    parameter int N = 4
);
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic           st;
    logic [N-1:0]   quociente;
    logic [N-1:0]   resto;
    logic           ovf;
    logic           done;
    logic           idle;

    modport master (
        output dividendo, divisor, st,
        input  quociente, resto, ovf, done, idle
    );

    modport slave (
        input  dividendo, divisor, st,
        output quociente, resto, ovf, done, idle
    );
endinterface
`default_nettype wire

// File: rtl/divisor_subtrai_desloca.sv
`default_nettype none
// ============================================================================
// Module      : divisor_subtrai_desloca
// Description : Sequential shift-subtract unsigned divider,
//               2N-bit dividendo / N-bit divisor -> N-bit quociente + resto.
//               Uses the same st/done/idle handshake as the shift-add
//               multiplier so both can share a control sequencer.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of divisor_subtrai_desloca_if
//                        (operands, st, quociente, resto, ovf, done, idle)
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_subtrai_desloca #(
    parameter int N = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    divisor_subtrai_desloca_if.slave     bus
);

    localparam int KW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [N:0]      r_rem;        // partial remainder, one guard bit
    logic [2*N-1:0]  r_a;          // dividend; low half becomes the quotient
    logic [N-1:0]    r_d;          // latched divisor
    logic [KW-1:0]   r_k;          // iteration counter
    logic [N-1:0]    r_quociente;
    logic [N-1:0]    r_resto;
    logic            r_ovf;
    logic            r_done;
    logic            r_idle;

    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N:0]      w_rem_next;
    logic [N-1:0]    w_q_next;
    logic            w_last;
    logic            w_ovf;

    // {R, A[N-1:0]} shifted left by one. R is always below D before the
    // shift, so the shifted value is below 2D and fits in N+1 bits.
    assign w_shift    = {r_rem[N-1:0], r_a[N-1]};
    assign w_ge       = (w_shift >= {1'b0, r_d});
    assign w_rem_next = w_ge ? (w_shift - {1'b0, r_d}) : w_shift;
    assign w_q_next   = {r_a[N-2:0], w_ge};
    assign w_last     = (r_k == KW'(N - 1));

    // Quotient fits in N bits only when the upper dividend half is below D;
    // this also catches D == 0.
    assign w_ovf      = (r_d == '0) || (r_a[2*N-1:N] >= r_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_a         <= '0;
            r_d         <= '0;
            r_k         <= '0;
            r_quociente <= '0;
            r_resto     <= '0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.st) begin
                        r_a     <= bus.dividendo;
                        r_d     <= bus.divisor;
                        r_ovf   <= 1'b0;
                        r_idle  <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_ovf) begin
                        r_ovf       <= 1'b1;
                        r_quociente <= '0;
                        r_resto     <= '0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_rem   <= {1'b0, r_a[2*N-1:N]};
                        r_k     <= '0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_rem       <= w_rem_next;
                    r_a[N-1:0]  <= w_q_next;
                    r_k         <= r_k + KW'(1);
                    if (w_last) begin
                        // Results are captured on entry to DONE from the
                        // values produced by this final iteration.
                        r_quociente <= w_q_next;
                        r_resto     <= w_rem_next[N-1:0];
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quociente = r_quociente;
    assign bus.resto     = r_resto;
    assign bus.ovf       = r_ovf;
    assign bus.done      = r_done;
    assign bus.idle      = r_idle;

endmodule
`default_nettype wire
